// File: rtl/audio_pkg.sv
// Shared types for the PCM sample FIFO: sample mode encoding, read-engine
// states and the helpers that turn a mode into a byte count and raw bytes
// into a left/right sample pair.
package audio_pkg;

    // Encoding is {mode_16bit, mode_stereo} so the raw inputs cast directly.
    typedef enum logic [1:0] {
        MODE_8M  = 2'b00,
        MODE_8S  = 2'b01,
        MODE_16M = 2'b10,
        MODE_16S = 2'b11
    } audio_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DONE  = 2'b10
    } rd_state_e;

    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } stereo_sample_t;

    localparam int MAX_BYTES = 4;

    function automatic logic [2:0] bytes_per_sample(input audio_mode_e mode);
        case (mode)
            MODE_8M:           return 3'd1;
            MODE_8S, MODE_16M: return 3'd2;
            default:           return 3'd4;
        endcase
    endfunction

    // Bytes arrive as L low, L high, R low, R high, using only what the mode needs.
    // 8-bit samples are left-justified into the 16-bit output.
    function automatic stereo_sample_t assemble_sample(input audio_mode_e mode,
                                                       input logic [MAX_BYTES-1:0][7:0] b);
        stereo_sample_t s;
        case (mode)
            MODE_8M: begin
                s.left  = {b[0], 8'h00};
                s.right = {b[0], 8'h00};
            end
            MODE_8S: begin
                s.left  = {b[0], 8'h00};
                s.right = {b[1], 8'h00};
            end
            MODE_16M: begin
                s.left  = {b[1], b[0]};
                s.right = {b[1], b[0]};
            end
            default: begin
                s.left  = {b[1], b[0]};
                s.right = {b[3], b[2]};
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/audio_sample_fifo_if.sv
// Bus between the CPU/DAC side and the sample FIFO. The master drives
// writes, requests and configuration; the slave (the FIFO) returns samples
// and status.
interface audio_sample_fifo_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        wrdata;
    logic              wr_en;
    logic              flush;
    logic              mode_16bit;
    logic              mode_stereo;
    logic [ADDR_W-1:0] ae_threshold;
    logic              rd_en;
    logic              clr_flags;

    logic              sample_valid;
    logic [15:0]       left;
    logic [15:0]       right;
    logic              busy;
    logic [ADDR_W-1:0] count;
    logic              empty;
    logic              almost_empty;
    logic              full;
    logic              overflow;
    logic              underrun;

    modport master (
        output wrdata, wr_en, flush, mode_16bit, mode_stereo, ae_threshold, rd_en, clr_flags,
        input  sample_valid, left, right, busy, count, empty, almost_empty, full, overflow, underrun
    );

    modport slave (
        input  wrdata, wr_en, flush, mode_16bit, mode_stereo, ae_threshold, rd_en, clr_flags,
        output sample_valid, left, right, busy, count, empty, almost_empty, full, overflow, underrun
    );

endinterface

// File: rtl/audio_fifo_ram.sv
// Byte-wide simple dual-port RAM: one write port, one synchronous read port.
// The array has no reset so it maps onto block RAM.
module audio_fifo_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem_q [0:(1<<ADDR_W)-1];
    logic [7:0] rdata_q;

    // Write port and registered read port; read data appears the cycle after re.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/audio_sample_fifo.sv
// PCM sample FIFO: byte writes in, whole 8/16-bit mono/stereo samples out on
// request. Holds the pointers, status, sticky flags and read engine.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for rd_en; accepts a request or flags underrun
// ST_FETCH | one byte read issued per cycle, previous byte captured
// ST_DONE  | sample_valid pulse with the assembled left/right pair
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    audio_sample_fifo_if.slave bus
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] wridx_q, wridx_d;
    logic [ADDR_W-1:0] rdidx_q, rdidx_d;
    logic [ADDR_W-1:0] count_w;
    logic              full_w;
    logic              empty_w;

    logic              ram_we;
    logic              ram_re;
    logic [7:0]        ram_rdata;

    rd_state_e         state_q, state_d;
    audio_mode_e       mode_q, mode_d;
    audio_mode_e       mode_in;
    logic [1:0]        idx_q, idx_d;
    logic [MAX_BYTES-1:0][7:0] bytes_q, bytes_d;
    logic [MAX_BYTES-1:0][7:0] bytes_view;
    stereo_sample_t    asm_w;
    logic [15:0]       left_q, left_d;
    logic [15:0]       right_q, right_d;
    logic [2:0]        n_req;
    logic [2:0]        n_cur;
    logic              enough_w;

    logic              overflow_q, overflow_d;
    logic              underrun_q, underrun_d;
    logic              overflow_evt;
    logic              underrun_evt;

    // Status from registered pointers only; no lookahead on same-cycle traffic.
    always_comb begin
        count_w = wridx_q - rdidx_q;
        empty_w = (wridx_q == rdidx_q);
        full_w  = ((wridx_q + PTR_ONE) == rdidx_q);
    end

    // Write side: accept when not full, drop and flag otherwise; flush discards.
    always_comb begin
        ram_we       = bus.wr_en && !full_w && !bus.flush;
        overflow_evt = bus.wr_en &&  full_w && !bus.flush;
    end

    // Read-engine next state, byte capture and sample assembly.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        idx_d        = idx_q;
        bytes_d      = bytes_q;
        left_d       = left_q;
        right_d      = right_q;
        ram_re       = 1'b0;
        underrun_evt = 1'b0;

        mode_in  = audio_mode_e'({bus.mode_16bit, bus.mode_stereo});
        n_req    = bytes_per_sample(mode_in);
        n_cur    = bytes_per_sample(mode_q);
        enough_w = (32'(count_w) >= 32'(n_req));

        // The byte returning this cycle, merged with those already captured,
        // so the last byte can be assembled without an extra cycle.
        bytes_view        = bytes_q;
        bytes_view[idx_q] = ram_rdata;
        asm_w             = assemble_sample(mode_q, bytes_view);

        case (state_q)
            ST_IDLE: begin
                if (bus.rd_en) begin
                    if (enough_w) begin
                        mode_d  = mode_in;
                        idx_d   = 2'd0;
                        ram_re  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        underrun_evt = 1'b1;
                        left_d       = 16'h0000;
                        right_d      = 16'h0000;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                bytes_d = bytes_view;
                if ({1'b0, idx_q} == (n_cur - 3'd1)) begin
                    left_d  = asm_w.left;
                    right_d = asm_w.right;
                    state_d = ST_DONE;
                end else begin
                    ram_re = 1'b1;
                    idx_d  = idx_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush aborts any fetch; the last delivered sample stays on the outputs.
        if (bus.flush) begin
            state_d      = ST_IDLE;
            idx_d        = 2'd0;
            ram_re       = 1'b0;
            underrun_evt = 1'b0;
            left_d       = left_q;
            right_d      = right_q;
        end
    end

    // Pointer update: each issued byte read advances rdidx immediately.
    always_comb begin
        wridx_d = ram_we ? (wridx_q + PTR_ONE) : wridx_q;
        rdidx_d = ram_re ? (rdidx_q + PTR_ONE) : rdidx_q;
        if (bus.flush) begin
            wridx_d = '0;
            rdidx_d = '0;
        end
    end

    // Sticky flags; a new event wins over a same-cycle clear.
    always_comb begin
        overflow_d = (overflow_q && !bus.clr_flags) || overflow_evt;
        underrun_d = (underrun_q && !bus.clr_flags) || underrun_evt;
    end

    // State, pointers, sample registers and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wridx_q    <= '0;
            rdidx_q    <= '0;
            state_q    <= ST_IDLE;
            mode_q     <= MODE_8M;
            idx_q      <= 2'd0;
            bytes_q    <= '0;
            left_q     <= 16'h0000;
            right_q    <= 16'h0000;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wridx_q    <= wridx_d;
            rdidx_q    <= rdidx_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            bytes_q    <= bytes_d;
            left_q     <= left_d;
            right_q    <= right_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    audio_fifo_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wridx_q),
        .wdata (bus.wrdata),
        .re    (ram_re),
        .raddr (rdidx_q),
        .rdata (ram_rdata)
    );

    // Bus outputs.
    always_comb begin
        bus.sample_valid = (state_q == ST_DONE);
        bus.busy         = (state_q != ST_IDLE);
        bus.left         = left_q;
        bus.right        = right_q;
        bus.count        = count_w;
        bus.empty        = empty_w;
        bus.full         = full_w;
        bus.almost_empty = (count_w < bus.ae_threshold);
        bus.overflow     = overflow_q;
        bus.underrun     = underrun_q;
    end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: a per-cycle vector table on a
// 4 KiB instance, plus hand-written fill, flush/reset and wrap sequences
// (the wrap and threshold work uses a 16-byte instance).
module tb_audio_sample_fifo;

    logic clk = 1'b0;
    logic rst12_n = 1'b0;
    logic rst4_n  = 1'b0;

    always #5 clk = ~clk;

    audio_sample_fifo_if #(.ADDR_W(12)) if12 ();
    audio_sample_fifo_if #(.ADDR_W(4))  if4 ();

    audio_sample_fifo #(.ADDR_W(12)) u_dut12 (
        .clk   (clk),
        .rst_n (rst12_n),
        .bus   (if12)
    );

    audio_sample_fifo #(.ADDR_W(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .bus   (if4)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  wd;
        logic        rd;
        logic        m16;
        logic        st;
        logic        clr;
        logic        fl;
        logic        sv;
        logic        busy;
        logic [11:0] cnt;
        logic [15:0] l;
        logic [15:0] r;
        logic        unf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic wr, input logic [7:0] wd, input logic rd,
                                input logic m16, input logic st, input logic clr, input logic fl,
                                input logic sv, input logic busy, input logic [11:0] cnt,
                                input logic [15:0] l, input logic [15:0] r, input logic unf);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.m16 = m16; v.st = st; v.clr = clr; v.fl = fl;
        v.sv = sv; v.busy = busy; v.cnt = cnt; v.l = l; v.r = r; v.unf = unf;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle12();
        if12.wr_en = 1'b0; if12.rd_en = 1'b0; if12.clr_flags = 1'b0; if12.flush = 1'b0;
    endtask

    task automatic idle4();
        if4.wr_en = 1'b0; if4.rd_en = 1'b0; if4.clr_flags = 1'b0; if4.flush = 1'b0;
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] eb;
    logic [7:0] b;
    logic       ae_exp [5];
    int written;
    int got;
    int cyc;

    initial begin
        if12.wrdata = 8'h00; if12.mode_16bit = 1'b0; if12.mode_stereo = 1'b0;
        if12.ae_threshold = 12'd0;
        idle12();
        if4.wrdata = 8'h00; if4.mode_16bit = 1'b0; if4.mode_stereo = 1'b0;
        if4.ae_threshold = 4'd4;
        idle4();

        // wr  data  rd m16 st clr fl | sv busy cnt  left     right    unf
        // 16-bit stereo: 11 22 33 44 -> 2211 / 4433; mode change and rd_en mid-fetch ignored
        add(1, 8'h11, 0, 1, 1, 0, 0,   0, 0, 1, 16'h0000, 16'h0000, 0);
        add(1, 8'h22, 0, 1, 1, 0, 0,   0, 0, 2, 16'h0000, 16'h0000, 0);
        add(1, 8'h33, 0, 1, 1, 0, 0,   0, 0, 3, 16'h0000, 16'h0000, 0);
        add(1, 8'h44, 0, 1, 1, 0, 0,   0, 0, 4, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 1, 1, 1, 0, 0,   0, 1, 3, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 0, 1, 1, 0, 0,   0, 1, 2, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0,   0, 1, 1, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0,   0, 1, 0, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 0, 1, 1, 0, 0,   1, 1, 0, 16'h2211, 16'h4433, 0);
        add(0, 8'h00, 0, 1, 1, 0, 0,   0, 0, 0, 16'h2211, 16'h4433, 0);
        // 8-bit mono: 80 -> 8000 after 2 cycles
        add(1, 8'h80, 0, 0, 0, 0, 0,   0, 0, 1, 16'h2211, 16'h4433, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0,   0, 1, 0, 16'h2211, 16'h4433, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0,   1, 1, 0, 16'h8000, 16'h8000, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 0, 16'h8000, 16'h8000, 0);
        // underrun on empty, clear, then clear colliding with a new underrun
        add(0, 8'h00, 1, 1, 1, 0, 0,   1, 1, 0, 16'h0000, 16'h0000, 1);
        add(0, 8'h00, 0, 1, 1, 1, 0,   0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 1, 1, 1, 1, 0,   1, 1, 0, 16'h0000, 16'h0000, 1);
        add(0, 8'h00, 0, 1, 1, 1, 0,   0, 0, 0, 16'h0000, 16'h0000, 0);
        // flush on 2nd FETCH cycle with a concurrent write, then restart from pointer 0
        add(1, 8'hAA, 0, 1, 1, 0, 0,   0, 0, 1, 16'h0000, 16'h0000, 0);
        add(1, 8'hBB, 0, 1, 1, 0, 0,   0, 0, 2, 16'h0000, 16'h0000, 0);
        add(1, 8'hCC, 0, 1, 1, 0, 0,   0, 0, 3, 16'h0000, 16'h0000, 0);
        add(1, 8'hDD, 0, 1, 1, 0, 0,   0, 0, 4, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 1, 1, 1, 0, 0,   0, 1, 3, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 0, 1, 1, 0, 0,   0, 1, 2, 16'h0000, 16'h0000, 0);
        add(1, 8'hEE, 0, 1, 1, 0, 1,   0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 0, 1, 1, 0, 0,   0, 0, 0, 16'h0000, 16'h0000, 0);
        add(1, 8'h5A, 0, 0, 0, 0, 0,   0, 0, 1, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0,   0, 1, 0, 16'h0000, 16'h0000, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0,   1, 1, 0, 16'h5A00, 16'h5A00, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 0, 16'h5A00, 16'h5A00, 0);
        // 8-bit stereo: 12 34 -> 1200 / 3400
        add(1, 8'h12, 0, 0, 1, 0, 0,   0, 0, 1, 16'h5A00, 16'h5A00, 0);
        add(1, 8'h34, 0, 0, 1, 0, 0,   0, 0, 2, 16'h5A00, 16'h5A00, 0);
        add(0, 8'h00, 1, 0, 1, 0, 0,   0, 1, 1, 16'h5A00, 16'h5A00, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0,   0, 1, 0, 16'h5A00, 16'h5A00, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0,   1, 1, 0, 16'h1200, 16'h3400, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0,   0, 0, 0, 16'h1200, 16'h3400, 0);
        // 16-bit mono: CD AB -> ABCD on both channels
        add(1, 8'hCD, 0, 1, 0, 0, 0,   0, 0, 1, 16'h1200, 16'h3400, 0);
        add(1, 8'hAB, 0, 1, 0, 0, 0,   0, 0, 2, 16'h1200, 16'h3400, 0);
        add(0, 8'h00, 1, 1, 0, 0, 0,   0, 1, 1, 16'h1200, 16'h3400, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0,   0, 1, 0, 16'h1200, 16'h3400, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0,   1, 1, 0, 16'hABCD, 16'hABCD, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0,   0, 0, 0, 16'hABCD, 16'hABCD, 0);

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst12_n = 1'b1;
        rst4_n  = 1'b1;
        tick();
        check("rst_empty",    32'(if12.empty), 32'd1);
        check("rst_full",     32'(if12.full), 32'd0);
        check("rst_ae_thr0",  32'(if12.almost_empty), 32'd0);
        check("rst_count",    32'(if12.count), 32'd0);
        check("rst_sv",       32'(if12.sample_valid), 32'd0);
        check("rst_busy",     32'(if12.busy), 32'd0);
        check("rst_left",     32'(if12.left), 32'd0);
        check("rst_right",    32'(if12.right), 32'd0);
        check("rst_flags",    32'({if12.overflow, if12.underrun}), 32'd0);
        check("rst_ae_thr4",  32'(if4.almost_empty), 32'd1);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            if12.wr_en       = vecs[i].wr;
            if12.wrdata      = vecs[i].wd;
            if12.rd_en       = vecs[i].rd;
            if12.mode_16bit  = vecs[i].m16;
            if12.mode_stereo = vecs[i].st;
            if12.clr_flags   = vecs[i].clr;
            if12.flush       = vecs[i].fl;
            tick();
            check($sformatf("v%0d_sv", i),    32'(if12.sample_valid), 32'(vecs[i].sv));
            check($sformatf("v%0d_busy", i),  32'(if12.busy), 32'(vecs[i].busy));
            check($sformatf("v%0d_count", i), 32'(if12.count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_empty", i), 32'(if12.empty), 32'(vecs[i].cnt == 12'd0));
            check($sformatf("v%0d_left", i),  32'(if12.left), 32'(vecs[i].l));
            check($sformatf("v%0d_right", i), 32'(if12.right), 32'(vecs[i].r));
            check($sformatf("v%0d_unf", i),   32'(if12.underrun), 32'(vecs[i].unf));
        end
        idle12();

        // Fill to capacity, overflow, clear
        for (int i = 0; i < 4094; i++) begin
            if12.wr_en  = 1'b1;
            if12.wrdata = 8'(i);
            tick();
        end
        check("fill_4094_full",  32'(if12.full), 32'd0);
        check("fill_4094_count", 32'(if12.count), 32'd4094);
        tick();
        check("fill_4095_full",  32'(if12.full), 32'd1);
        check("fill_4095_count", 32'(if12.count), 32'd4095);
        check("fill_4095_ovf",   32'(if12.overflow), 32'd0);
        tick();
        check("ovf_set",         32'(if12.overflow), 32'd1);
        check("ovf_count",       32'(if12.count), 32'd4095);
        if12.wr_en     = 1'b0;
        if12.clr_flags = 1'b1;
        tick();
        check("ovf_clr",         32'(if12.overflow), 32'd0);
        if12.clr_flags = 1'b0;
        if12.flush     = 1'b1;
        tick();
        check("flush_count",     32'(if12.count), 32'd0);
        check("flush_empty",     32'(if12.empty), 32'd1);
        idle12();

        // Async reset in the middle of a fetch
        if12.mode_16bit  = 1'b1;
        if12.mode_stereo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if12.wr_en  = 1'b1;
            if12.wrdata = 8'(8'h61 + i);
            tick();
        end
        if12.wr_en = 1'b0;
        if12.rd_en = 1'b1;
        tick();
        if12.rd_en = 1'b0;
        tick();
        check("prerst_busy", 32'(if12.busy), 32'd1);
        #2;
        rst12_n = 1'b0;
        #1;
        check("arst_busy",  32'(if12.busy), 32'd0);
        check("arst_count", 32'(if12.count), 32'd0);
        check("arst_left",  32'(if12.left), 32'd0);
        check("arst_right", 32'(if12.right), 32'd0);
        check("arst_empty", 32'(if12.empty), 32'd1);
        @(negedge clk);
        rst12_n = 1'b1;
        tick();
        check("arst_sv", 32'(if12.sample_valid), 32'd0);

        // Stream 100 bytes through the 16-byte FIFO with an 8-bit mono reader.
        // The reader also holds rd_en high while busy; those must be ignored.
        written = 0;
        got     = 0;
        cyc     = 0;
        while (got < 100 && cyc < 3000) begin
            if4.wr_en = (written < 100) && !if4.full;
            if (if4.wr_en) begin
                b = 8'(written * 7 + 3);
                if4.wrdata = b;
                exp_q.push_back(b);
                written++;
            end
            if4.rd_en = if4.busy || !if4.empty;
            tick();
            cyc++;
            if (if4.sample_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra_sample", 32'd1, 32'd0);
                end else begin
                    eb = exp_q.pop_front();
                    check($sformatf("stream_s%0d", got), 32'(if4.left), 32'({eb, 8'h00}));
                end
                got++;
            end
        end
        idle4();
        check("stream_samples", 32'(got), 32'd100);
        check("stream_leftover", 32'(exp_q.size()), 32'd0);
        check("stream_ovf", 32'(if4.overflow), 32'd0);
        check("stream_unf", 32'(if4.underrun), 32'd0);

        // Almost-empty threshold at 4
        if4.flush = 1'b1;
        tick();
        if4.flush = 1'b0;
        check("ae_cnt0", 32'(if4.almost_empty), 32'd1);
        ae_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            if4.wr_en  = 1'b1;
            if4.wrdata = 8'(k);
            tick();
            check($sformatf("ae_wr_cnt%0d", k + 1), 32'(if4.almost_empty), 32'(ae_exp[k]));
        end
        if4.wr_en = 1'b0;
        if4.rd_en = 1'b1;
        tick();
        if4.rd_en = 1'b0;
        check("ae_rd_cnt4_count", 32'(if4.count), 32'd4);
        check("ae_rd_cnt4", 32'(if4.almost_empty), 32'd0);
        tick();
        tick();
        if4.rd_en = 1'b1;
        tick();
        if4.rd_en = 1'b0;
        check("ae_rd_cnt3_count", 32'(if4.count), 32'd3);
        check("ae_rd_cnt3", 32'(if4.almost_empty), 32'd1);
        tick();
        tick();

        // Full on the small FIFO after wrap
        if4.flush = 1'b1;
        tick();
        if4.flush = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if4.wr_en  = 1'b1;
            if4.wrdata = 8'(k);
            tick();
        end
        if4.wr_en = 1'b0;
        check("small_full", 32'(if4.full), 32'd1);
        check("small_count", 32'(if4.count), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Parametrised PCM sample buffer between the CPU-side audio data register and the audio DAC sample engine. It accepts byte writes and returns whole samples on request: 8- or 16-bit, mono or stereo. It also provides a programmable almost-empty threshold, an occupancy count, and sticky overflow/underrun flags. It replaces the fixed 4 KiB byte FIFO in the audio path.

## Interface
- `ADDR_W`, 12: log2 of buffer depth in bytes. Usable capacity is 2^ADDR_W − 1 bytes.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wrdata` in 8: byte to push.
- `wr_en` in 1: push `wrdata` this cycle.
- `flush` in 1: synchronous clear of both pointers, the read engine and `sample_valid`.
- `mode_16bit` in 1: 1 selects 16-bit little-endian samples; 0 selects 8-bit signed samples.
- `mode_stereo` in 1: 1 means each sample is an interleaved L,R pair.
- `ae_threshold` in ADDR_W: `almost_empty` asserts when `count` < this value.
- `rd_en` in 1: sample request; a single-cycle pulse from the DAC engine.
- `clr_flags` in 1: clears `overflow` and `underrun`.
- `sample_valid` out 1: one-cycle pulse; `left` and `right` are valid on this cycle.
- `left` out 16: left (or mono) sample.
- `right` out 16: right sample; equals `left` in mono.
- `busy` out 1: read engine is not in IDLE.
- `count` out ADDR_W: occupied bytes, `wridx − rdidx` modulo 2^ADDR_W.
- `empty`, `almost_empty`, `full` out 1 each: status.
- `overflow`, `underrun` out 1 each: sticky error flags.

## Operation
- Reset values: pointers 0, `left` = `right` = 0, `sample_valid` = 0, `busy` = 0, `overflow` = `underrun` = 0, state IDLE. After reset `empty` = 1, `full` = 0, and `almost_empty` = (`ae_threshold` ≠ 0).
- Write path:
  - `wr_en && !full` stores the byte and increments `wridx`.
  - `wr_en && full` drops the byte and sets `overflow`.
- Bytes per sample, N:
  - 8-bit mono: 1
  - 8-bit stereo: 2
  - 16-bit mono: 2
  - 16-bit stereo: 4
- Mode is latched when a request is accepted. Mode changes mid-fetch do not affect the sample in progress.
- Read engine states:
  - **IDLE**: on `rd_en`:
    - If `count` ≥ N: latch mode, issue the read of byte 0, go to FETCH.
    - If `count` < N: consume nothing, set `underrun`, go to DONE with `left` = `right` = 0.
  - **FETCH**: issue one byte read per cycle until N reads have been issued. Capture each returned byte one cycle after it was issued. Go to DONE after the last capture.
  - **DONE**: assert `sample_valid` for one cycle, return to IDLE.
- Byte order is L low, L high, R low, R high, with only the bytes the mode requires.
- An 8-bit sample byte b maps to {b, 8'h00}.
- A 16-bit sample is {high, low}.
- `rd_en` while `busy` is ignored. It is neither queued nor flagged.
- The read pointer advances when each byte read is issued, so `count` decrements per byte during FETCH.
- `left` and `right` hold their values between samples.

## Timing
- Memory read is synchronous: data is available one cycle after the address.
- Latency: `sample_valid` is asserted N+1 cycles after the cycle in which `rd_en` is accepted. That is 2 cycles for 8-bit mono and 5 cycles for 16-bit stereo. An underrun response takes 1 cycle.
- Simultaneous write and read byte: both take effect and `count` is unchanged. `full` and `empty` are computed from registered pointers, not lookahead.
- `flush` has priority over everything:
  - Pointers go to 0 and state goes to IDLE.
  - Any fetch in progress is aborted with no `sample_valid`.
  - A concurrent `wr_en` is discarded.
  - `left` and `right` keep their values.
- `clr_flags` in the same cycle as a new error event: the flag ends set, because the set wins.
- Pointer wrap is natural modulo 2^ADDR_W. `full` = (`wridx` + 1 == `rdidx`).
- `rst_n` asserted mid-fetch returns everything to its reset values immediately, without waiting for a clock edge.

## Structure
- The shared package `audio_pkg` holds:
  - the mode encoding (`MODE_8M`, `MODE_8S`, `MODE_16M`, `MODE_16S`)
  - the read-engine state enum
  - a `bytes_per_sample(mode)` function
- Sub-module `audio_fifo_ram`: parametrised simple dual-port RAM (8 × 2^ADDR_W), one write port and one synchronous read port, with no reset on the array.
- The top level contains the pointers, status logic, flags and read-engine FSM.

## Test plan
- 16-bit stereo: write 11 22 33 44, pulse `rd_en` → `sample_valid` 5 cycles later with `left` = 16'h2211, `right` = 16'h4433, and `count` = 0.
- 8-bit mono: write 80, pulse `rd_en` → `left` = `right` = 16'h8000 after 2 cycles.
- Fill 4095 bytes with ADDR_W = 12 → `full` = 1. One more write → byte dropped, `overflow` = 1, `count` = 4095. `clr_flags` → `overflow` = 0.
- Empty FIFO in 16-bit stereo mode, `rd_en` → `underrun` = 1, `sample_valid` after 1 cycle with zeros, `count` stays 0.
- 16-bit stereo: `flush` on the 2nd cycle of FETCH → no `sample_valid`, `count` = 0, `busy` = 0 the next cycle. A subsequent write/read works from pointer 0.
- Wrap and thresholds with ADDR_W = 4 and `ae_threshold` = 4:
  - Stream 100 bytes with a concurrent 8-bit mono reader → data order preserved across pointer wrap.
  - `almost_empty` toggles exactly at `count` 3↔4.
  - `rd_en` pulses during `busy` are ignored.
